// File: rtl/seq_pattern_tx.sv
// Serial pattern transmitter: sends a captured pattern MSB-first, reps+1 times, with GAP idle cycles between.
// Optional build macro SEQ_TX_PARITY_EN appends an even-parity bit after each pattern.
module seq_pattern_tx #(
    parameter int PAT_W = 3,
    parameter int GAP   = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [PAT_W-1:0] pat,
    input  logic [3:0]       reps,
    output logic             out,
    output logic             valid,
    output logic             busy,
    output logic             done
);
`ifdef SEQ_TX_PARITY_EN
    localparam int BITS = PAT_W + 1;
`else
    localparam int BITS = PAT_W;
`endif
    localparam int BIT_CW = $clog2(PAT_W + 1);
    localparam int GAP_CW = (GAP > 0) ? $clog2(GAP + 1) : 1;
    localparam logic [BIT_CW-1:0] BIT_LAST = BIT_CW'(BITS - 1);
    localparam logic [GAP_CW-1:0] GAP_LAST = GAP_CW'((GAP > 0) ? GAP - 1 : 0);

    typedef enum logic [1:0] {S_IDLE, S_SEND, S_GAP, S_DONE} state_t;

    state_t              state, state_n;
    logic [BIT_CW-1:0]   bit_cnt, bit_n;
    logic [GAP_CW-1:0]   gap_cnt, gap_n;
    logic [3:0]          rep_cnt, rep_n;
    logic [PAT_W-1:0]    shreg, shreg_n;
    logic [PAT_W-1:0]    pat_q, pat_n;
    logic                out_n, valid_n, busy_n, done_n;
`ifdef SEQ_TX_PARITY_EN
    logic                par_q, par_n;
`endif

    // Repetition count never wraps below zero.
    function automatic logic [3:0] dec_sat(input logic [3:0] v);
        return (v != 4'd0) ? v - 4'd1 : 4'd0;
    endfunction

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= S_IDLE;
            bit_cnt <= '0;
            gap_cnt <= '0;
            rep_cnt <= '0;
            out     <= 1'b0;
            valid   <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            state   <= state_n;
            bit_cnt <= bit_n;
            gap_cnt <= gap_n;
            rep_cnt <= rep_n;
            out     <= out_n;
            valid   <= valid_n;
            busy    <= busy_n;
            done    <= done_n;
        end
    end

    always_ff @(posedge clk) begin
        shreg <= shreg_n;
        pat_q <= pat_n;
`ifdef SEQ_TX_PARITY_EN
        par_q <= par_n;
`endif
    end

    always_comb begin
        state_n = state;
        bit_n   = bit_cnt;
        gap_n   = gap_cnt;
        rep_n   = rep_cnt;
        shreg_n = shreg;
        pat_n   = pat_q;
`ifdef SEQ_TX_PARITY_EN
        par_n   = par_q;
`endif
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_n = S_SEND;
                    shreg_n = pat;
                    pat_n   = pat;
                    rep_n   = reps;
                    bit_n   = '0;
                    gap_n   = '0;
`ifdef SEQ_TX_PARITY_EN
                    par_n   = ^pat;
`endif
                end
            end
            S_SEND: begin
                if (bit_cnt != BIT_LAST) begin
                    bit_n   = bit_cnt + BIT_CW'(1);
                    shreg_n = shreg << 1;
                end else begin
                    bit_n = '0;
                    if (rep_cnt == 4'd0) begin
                        state_n = S_DONE;
                    end else if (GAP > 0) begin
                        state_n = S_GAP;
                        gap_n   = '0;
                    end else begin
                        shreg_n = pat_q;
                        rep_n   = dec_sat(rep_cnt);
                    end
                end
            end
            S_GAP: begin
                if (gap_cnt == GAP_LAST) begin
                    state_n = S_SEND;
                    gap_n   = '0;
                    shreg_n = pat_q;
                    rep_n   = dec_sat(rep_cnt);
                end else begin
                    gap_n = gap_cnt + GAP_CW'(1);
                end
            end
            S_DONE:  state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase
    end

    // Outputs are decoded from the next state so they register in step with it.
    always_comb begin
        out_n   = 1'b0;
        valid_n = 1'b0;
        busy_n  = 1'b0;
        done_n  = 1'b0;
        case (state_n)
            S_SEND: begin
                valid_n = 1'b1;
                busy_n  = 1'b1;
`ifdef SEQ_TX_PARITY_EN
                out_n   = (bit_n == BIT_CW'(PAT_W)) ? par_n : shreg_n[PAT_W-1];
`else
                out_n   = shreg_n[PAT_W-1];
`endif
            end
            S_GAP:   busy_n = 1'b1;
            S_DONE:  done_n = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: doc/seq_pattern_tx.md
# seq_pattern_tx

Serial pattern transmitter: the generating end of the serial sequence detectors in the FSM library. On a start request it captures a PAT_W-bit pattern and a repetition count, then drives the pattern MSB-first on a single-bit serial line, one bit per clock. Repetitions are separated by a programmable number of idle gap cycles. It feeds the detectors directly and serves as their stimulus source in system-level checks.

## Interface
- PAT_W, 3, pattern width in bits (2..16)
- GAP, 1, idle cycles inserted between repetitions (0..15; 0 = back-to-back)
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-low reset (rst=0 resets)
- start  input  1  burst request; sampled only in IDLE
- pat  input  PAT_W  pattern; captured on accepted start
- reps  input  4  extra repetitions; burst sends reps+1 patterns; captured on accepted start
- out  output  1  serial data, registered
- valid  output  1  high while `out` carries a pattern (or parity) bit
- busy  output  1  high from the cycle after start acceptance through the last bit/gap
- done  output  1  one-cycle pulse after the final bit of the burst

## Operation
- All outputs are registered (Moore). Reset value: out=0, valid=0, busy=0, done=0, state=IDLE, all counters 0.
- States:
  - IDLE: outputs low.
    - start=1 → capture pat into the shift register and reps into the rep counter; go to SEND.
  - SEND: out=current MSB, valid=1, busy=1.
    - Shift left each cycle; the bit counter counts PAT_W bits.
    - After the last bit:
      - if rep counter > 0 and GAP > 0 → GAP
      - if rep counter > 0 and GAP = 0 → reload the shift register from the captured pattern and stay in SEND (rep counter −1)
      - if rep counter = 0 → DONE
  - GAP: out=0, valid=0, busy=1.
    - After GAP cycles, reload the pattern, decrement the rep counter, and go to SEND.
  - DONE: done=1, busy=0, valid=0, out=0. Go to IDLE unconditionally next cycle.
- start is ignored in SEND, GAP and DONE. A start held high continuously launches the next burst on the first IDLE cycle after DONE.
- Changes to pat or reps while busy have no effect; the captured copies are used.
- Counter widths:
  - bit counter: $clog2(PAT_W+1)
  - gap counter: $clog2(GAP+1), minimum 1
  - rep counter: 4 bits, no wrap (it decrements only when nonzero).
- Illegal or unreachable state encoding → IDLE with outputs low.

## Timing
- start=1 sampled at edge k (in IDLE) → first bit on out, valid=1, busy=1 from edge k+1.
- Burst length from edge k+1: (reps+1)·B + reps·GAP cycles, where B = PAT_W (or PAT_W+1 with parity).
- done is high for exactly one cycle, immediately after the last bit. busy is already low in that cycle.
- Earliest next acceptance: the IDLE cycle after DONE, i.e. 2 cycles after the last bit.
- Asynchronous reset assertion mid-burst forces all outputs low immediately. No done pulse is issued. After deassertion the block is in IDLE and needs a fresh start.

## Configuration
- SEQ_TX_PARITY_EN defined:
  - One extra bit follows each pattern in SEND: even parity, equal to the XOR of the captured pattern bits, with valid=1.
  - Any gap comes after the parity bit.
- SEQ_TX_PARITY_EN undefined: no parity bit; B = PAT_W. The port list is identical in both builds.

## Test plan
- Defaults, pat=3'b101, reps=0, start pulse at edge 0:
  - out=1,0,1 with valid=1 at cycles 1–3
  - done=1 at cycle 4, busy=0 from cycle 4
  - a connected 101 detector pulses once.
- pat=3'b101, reps=2, GAP=1:
  - out/valid = 1,0,1,(0/v0),1,0,1,(0/v0),1,0,1 over cycles 1–11
  - done at cycle 12.
- GAP=0, pat=3'b110, reps=1:
  - out=1,1,0,1,1,0 continuous with valid=1 at cycles 1–6
  - done at cycle 7.
- pat=3'b101, reps=3, with a new start and a changed pat=3'b011 pulsed during the burst:
  - the changes are ignored; four 101 patterns are sent.
  - start held high after done → next burst begins 2 cycles after the last bit.
- rst driven low at cycle 2 of a burst: out, valid, busy and done are 0 immediately. After release the outputs stay idle until the next start.
- SEQ_TX_PARITY_EN defined:
  - pat=3'b110 → out=1,1,0,0, done at cycle 5.
  - pat=3'b100 → out=1,0,0,1.
